// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared pipeline types: load-op encoding and reset PC.
// Revision    : 1.0
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } ld_op_t;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'hBFC0_0000;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Little-endian load extraction incl. LWL/LWR merge (pure comb).
// Revision    : 1.0
// ============================================================================
module load_align
    import cpu_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    input  logic [31:0] alu,
    output logic [31:0] wdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[{addr, 3'b000} +: 8];
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wdata = alu;
        case (ld_op_t'(ld_op))
            LD_NONE: wdata = alu;
            LD_LB:   wdata = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  wdata = {24'h0, w_byte};
            LD_LH:   wdata = {{16{w_half[15]}}, w_half};
            LD_LHU:  wdata = {16'h0, w_half};
            LD_LW:   wdata = rdata;
            LD_LWL: begin
                // Memory bytes fill from the MSB end; unloaded low bytes keep rt
                case (addr)
                    2'd0:    wdata = {rdata[7:0],  rt[23:0]};
                    2'd1:    wdata = {rdata[15:0], rt[15:0]};
                    2'd2:    wdata = {rdata[23:0], rt[7:0]};
                    default: wdata = rdata;
                endcase
            end
            LD_LWR: begin
                case (addr)
                    2'd0:    wdata = rdata;
                    2'd1:    wdata = {rt[31:24], rdata[31:8]};
                    2'd2:    wdata = {rt[31:16], rdata[31:16]};
                    default: wdata = {rt[31:8],  rdata[31:24]};
                endcase
            end
            default: wdata = alu;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : WB stage: load extraction, register-file write, WB bypass,
//               retired-instruction counter.
// Revision    : 1.0
// ============================================================================
module writeback_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_alu_result,
    input  logic [31:0] ms_rt_value,
    input  logic [4:0]  ms_dest,
    input  logic        ms_rf_we,
    input  logic [2:0]  ms_ld_op,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_stall,
    input  logic        ws_flush,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        forward_wb_wen,
    output logic [4:0]  forward_wb_regsrc,
    output logic [31:0] forward_wb_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [31:0] retired_cnt
);

    logic        r_ws_valid;
    logic        r_ws_first;
    logic [31:0] r_ws_pc;
    logic [31:0] r_ws_addr;
    logic [31:0] r_ws_rt;
    logic [4:0]  r_ws_dest;
    logic        r_ws_rf_we;
    logic [2:0]  r_ws_ld_op;
    logic [31:0] r_ws_rdata_hold;
    logic [31:0] r_retired_cnt;

    logic        w_ready_go;
    logic        w_allowin;
    logic        w_commit;
    logic        w_writes_reg;
    logic [31:0] w_rdata;
    logic [31:0] w_wdata;

    always_comb begin
        w_ready_go   = ~ws_stall;
        w_allowin    = ~r_ws_valid | (w_ready_go & ~ws_flush) | ws_flush;
        w_commit     = r_ws_valid & w_ready_go & ~ws_flush;
        w_writes_reg = r_ws_rf_we & (r_ws_dest != 5'd0);
        // SRAM data is only valid in the first WB cycle; afterwards use the copy
        w_rdata      = r_ws_first ? data_sram_rdata : r_ws_rdata_hold;
    end

    load_align u_load_align (
        .ld_op (r_ws_ld_op),
        .addr  (r_ws_addr[1:0]),
        .rdata (w_rdata),
        .rt    (r_ws_rt),
        .alu   (r_ws_addr),
        .wdata (w_wdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ws_valid      <= 1'b0;
            r_ws_first      <= 1'b0;
            r_ws_pc         <= PC_RESET;
            r_ws_addr       <= 32'h0;
            r_ws_rt         <= 32'h0;
            r_ws_dest       <= 5'd0;
            r_ws_rf_we      <= 1'b0;
            r_ws_ld_op      <= 3'd0;
            r_ws_rdata_hold <= 32'h0;
            r_retired_cnt   <= 32'h0;
        end else begin
            if (ms_to_ws_valid && w_allowin) begin
                r_ws_valid <= 1'b1;
                r_ws_first <= 1'b1;
                r_ws_pc    <= ms_pc;
                r_ws_addr  <= ms_alu_result;
                r_ws_rt    <= ms_rt_value;
                r_ws_dest  <= ms_dest;
                r_ws_rf_we <= ms_rf_we;
                r_ws_ld_op <= ms_ld_op;
            end else begin
                if (w_allowin) begin
                    r_ws_valid <= 1'b0;
                end
                r_ws_first <= 1'b0;
            end
            if (r_ws_first) begin
                r_ws_rdata_hold <= data_sram_rdata;
            end
            if (w_commit) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        ws_allowin        = w_allowin;
        rf_we             = w_commit & w_writes_reg;
        rf_waddr          = r_ws_dest;
        rf_wdata          = w_wdata;
        forward_wb_wen    = r_ws_valid & w_writes_reg & ~ws_flush;
        forward_wb_regsrc = r_ws_dest;
        forward_wb_wdata  = w_wdata;
        debug_wb_pc       = r_ws_pc;
        retired_cnt       = r_retired_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Self-checking bench for writeback_stage (directed + random).
// Revision    : 1.0
// ============================================================================
module tb_writeback_stage;

    localparam logic [31:0] C_PC_RST = 32'hBFC0_0000;
    localparam logic [2:0]  C_NONE = 3'd0, C_LB = 3'd1, C_LBU = 3'd2, C_LH = 3'd3,
                            C_LHU = 3'd4, C_LW = 3'd5, C_LWL = 3'd6, C_LWR = 3'd7;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [31:0] ms_alu_result;
    logic [31:0] ms_rt_value;
    logic [4:0]  ms_dest;
    logic        ms_rf_we;
    logic [2:0]  ms_ld_op;
    logic [31:0] data_sram_rdata;
    logic        ws_stall;
    logic        ws_flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        forward_wb_wen;
    logic [4:0]  forward_wb_regsrc;
    logic [31:0] forward_wb_wdata;
    logic [31:0] debug_wb_pc;
    logic [31:0] retired_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ret  = 32'h0;

    always #5 clk = ~clk;

    writeback_stage #(.PC_RESET(C_PC_RST)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allowin        (ws_allowin),
        .ms_pc             (ms_pc),
        .ms_alu_result     (ms_alu_result),
        .ms_rt_value       (ms_rt_value),
        .ms_dest           (ms_dest),
        .ms_rf_we          (ms_rf_we),
        .ms_ld_op          (ms_ld_op),
        .data_sram_rdata   (data_sram_rdata),
        .ws_stall          (ws_stall),
        .ws_flush          (ws_flush),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .forward_wb_wen    (forward_wb_wen),
        .forward_wb_regsrc (forward_wb_regsrc),
        .forward_wb_wdata  (forward_wb_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .retired_cnt       (retired_cnt)
    );

    // Reference load result from byte-lane arithmetic
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] r, input logic [31:0] rt);
        int          a;
        int          sh;
        logic [31:0] v;
        a = int'(addr[1:0]);
        v = addr;
        case (op)
            C_LB, C_LBU: begin
                v = (r >> (8 * a)) & 32'hFF;
                if (op == C_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            C_LH, C_LHU: begin
                v = (r >> (16 * (a / 2))) & 32'hFFFF;
                if (op == C_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            C_LW: v = r;
            C_LWL: begin
                sh = (3 - a) * 8;
                v  = (r << sh) | (rt & ((32'h1 << sh) - 32'h1));
            end
            C_LWR: begin
                sh = a * 8;
                v  = (r >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            end
            default: v = addr;
        endcase
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic idle_inputs;
        ms_to_ws_valid  = 1'b0;
        ms_pc           = 32'h0;
        ms_alu_result   = 32'h0;
        ms_rt_value     = 32'h0;
        ms_dest         = 5'd0;
        ms_rf_we        = 1'b0;
        ms_ld_op        = 3'd0;
        data_sram_rdata = 32'h0;
        ws_stall        = 1'b0;
        ws_flush        = 1'b0;
    endtask

    task automatic put(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] dest, input logic we);
        ms_to_ws_valid = 1'b1;
        ms_ld_op       = op;
        ms_pc          = pc;
        ms_alu_result  = alu;
        ms_rt_value    = rt;
        ms_dest        = dest;
        ms_rf_we       = we;
    endtask

    task automatic test_reset;
        idle_inputs();
        resetn = 1'b0;
        #12;
        n_checks++; if (ws_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %h want 1", ws_allowin); end
        n_checks++; if (debug_wb_pc !== C_PC_RST) begin n_fail++; $display("FAIL reset_pc: got %h want %h", debug_wb_pc, C_PC_RST); end
        n_checks++; if (rf_we !== 1'b0 || forward_wb_wen !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b/%b want 0/0", rf_we, forward_wb_wen); end
        n_checks++; if (retired_cnt !== 32'h0 || rf_wdata !== 32'h0 || rf_waddr !== 5'd0) begin
            n_fail++; $display("FAIL reset_data: got cnt=%h wdata=%h waddr=%h want zeros", retired_cnt, rf_wdata, rf_waddr); end
        tick();
        resetn = 1'b1;
        settle();
        n_checks++; if (ws_allowin !== 1'b1 || rf_we !== 1'b0 || retired_cnt !== 32'h0) begin
            n_fail++; $display("FAIL reset_release: got allowin=%b we=%b cnt=%h want 1/0/0", ws_allowin, rf_we, retired_cnt); end
        tick();
    endtask

    task automatic test_loads;
        logic [2:0]  ops   [4] = '{C_LB, C_LBU, C_LWL, C_LWR};
        logic [31:0] addrs [4] = '{32'h1003, 32'h1003, 32'h2001, 32'h2002};
        logic [31:0] rds   [4] = '{32'h8012_3456, 32'h8012_3456, 32'hAABB_CCDD, 32'hAABB_CCDD};
        logic [31:0] rts   [4] = '{32'h0, 32'h0, 32'h1122_3344, 32'h1122_3344};
        logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hCCDD_3344, 32'h1122_AABB};
        for (int i = 0; i < 4; i++) begin
            put(ops[i], 32'h100 + 32'(i * 4), addrs[i], rts[i], 5'd5, 1'b1);
            tick();
            ms_to_ws_valid  = 1'b0;
            data_sram_rdata = rds[i];
            settle();
            n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin
                n_fail++; $display("FAIL load%0d_we: got we=%b waddr=%0d want 1/5", i, rf_we, rf_waddr); end
            n_checks++; if (rf_wdata !== exps[i]) begin
                n_fail++; $display("FAIL load%0d_wdata: got %h want %h", i, rf_wdata, exps[i]); end
            n_checks++; if (debug_wb_pc !== 32'h100 + 32'(i * 4)) begin
                n_fail++; $display("FAIL load%0d_pc: got %h want %h", i, debug_wb_pc, 32'h100 + 32'(i * 4)); end
            tick();
            exp_ret++;
            settle();
            n_checks++; if (retired_cnt !== exp_ret || rf_we !== 1'b0) begin
                n_fail++; $display("FAIL load%0d_retire: got cnt=%h we=%b want %h/0", i, retired_cnt, rf_we, exp_ret); end
        end
    endtask

    task automatic test_stall_hold;
        put(C_LW, 32'h300, 32'h0000_0200, 32'h0, 5'd9, 1'b1);
        tick();
        ms_to_ws_valid  = 1'b0;
        ws_stall        = 1'b1;
        data_sram_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                tick();
                data_sram_rdata = 32'h0;
            end
            settle();
            n_checks++; if (forward_wb_wen !== 1'b1 || forward_wb_wdata !== 32'hDEAD_BEEF || forward_wb_regsrc !== 5'd9) begin
                n_fail++; $display("FAIL stall%0d_fwd: got wen=%b data=%h src=%0d want 1/deadbeef/9", i, forward_wb_wen, forward_wb_wdata, forward_wb_regsrc); end
            n_checks++; if (rf_we !== 1'b0 || ws_allowin !== 1'b0) begin
                n_fail++; $display("FAIL stall%0d_hold: got we=%b allowin=%b want 0/0", i, rf_we, ws_allowin); end
        end
        tick();
        ws_stall = 1'b0;
        settle();
        n_checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL stall_commit: got we=%b wdata=%h want 1/deadbeef", rf_we, rf_wdata); end
        tick();
        exp_ret++;
        settle();
        n_checks++; if (retired_cnt !== exp_ret || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL stall_retire: got cnt=%h we=%b want %h/0", retired_cnt, rf_we, exp_ret); end
    endtask

    task automatic test_dest_zero;
        put(C_NONE, 32'h400, 32'h0000_1234, 32'h0, 5'd0, 1'b1);
        tick();
        ms_to_ws_valid = 1'b0;
        settle();
        n_checks++; if (rf_we !== 1'b0 || forward_wb_wen !== 1'b0) begin
            n_fail++; $display("FAIL r0_we: got we=%b fwd=%b want 0/0", rf_we, forward_wb_wen); end
        n_checks++; if (rf_wdata !== 32'h1234) begin
            n_fail++; $display("FAIL r0_wdata: got %h want 00001234", rf_wdata); end
        tick();
        exp_ret++;
        settle();
        n_checks++; if (retired_cnt !== exp_ret) begin
            n_fail++; $display("FAIL r0_retire: got %h want %h", retired_cnt, exp_ret); end
    endtask

    task automatic test_back_to_back;
        put(C_NONE, 32'h500, 32'h55, 32'h0, 5'd1, 1'b1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (k < 5) put(C_NONE, 32'h500 + 32'(k * 4), 32'h55 + 32'(k * 256), 32'h0, 5'(k + 1), 1'b1);
            else ms_to_ws_valid = 1'b0;
            ws_flush = (k == 3);
            settle();
            n_checks++; if (ws_allowin !== 1'b1) begin
                n_fail++; $display("FAIL b2b%0d_allowin: got %b want 1", k, ws_allowin); end
            if (k == 3) begin
                n_checks++; if (rf_we !== 1'b0 || forward_wb_wen !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_flush: got we=%b fwd=%b want 0/0", rf_we, forward_wb_wen); end
            end else begin
                n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== 32'h55 + 32'((k - 1) * 256)) begin
                    n_fail++; $display("FAIL b2b%0d_write: got we=%b waddr=%0d wdata=%h want 1/%0d/%h",
                                       k, rf_we, rf_waddr, rf_wdata, k, 32'h55 + 32'((k - 1) * 256)); end
            end
            tick();
        end
        ws_flush = 1'b0;
        exp_ret  = exp_ret + 32'd4;
        settle();
        n_checks++; if (retired_cnt !== exp_ret || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL b2b_retire: got cnt=%h we=%b want %h/0", retired_cnt, rf_we, exp_ret); end
    endtask

    task automatic test_random;
        logic        m_valid = 1'b0, m_first = 1'b0, m_we = 1'b0;
        logic [2:0]  m_op = 3'd0;
        logic [31:0] m_pc = 32'h0, m_addr = 32'h0, m_rt = 32'h0, m_r = 32'h0, exp_w;
        logic [4:0]  m_dest = 5'd0;
        logic        commit, allow, e_rfwe, e_fwd;
        for (int c = 0; c < 400; c++) begin
            ws_stall        = ($urandom_range(0, 3) == 0);
            ws_flush        = ($urandom_range(0, 9) == 0);
            ms_to_ws_valid  = ($urandom_range(0, 3) != 0);
            ms_pc           = $urandom;
            ms_alu_result   = $urandom;
            ms_rt_value     = $urandom;
            ms_dest         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ms_rf_we        = ($urandom_range(0, 4) != 0);
            ms_ld_op        = 3'($urandom_range(0, 7));
            data_sram_rdata = $urandom;
            if (m_first) m_r = data_sram_rdata;
            commit = m_valid && !ws_stall && !ws_flush;
            e_fwd  = m_valid && m_we && (m_dest != 5'd0) && !ws_flush;
            e_rfwe = commit && m_we && (m_dest != 5'd0);
            allow  = !m_valid || !ws_stall || ws_flush;
            exp_w  = ref_load(m_op, m_addr, m_r, m_rt);
            settle();
            n_checks++; if (rf_we !== e_rfwe || forward_wb_wen !== e_fwd || ws_allowin !== allow) begin
                n_fail++; $display("FAIL rnd%0d_ctrl: got we=%b fwd=%b allow=%b want %b/%b/%b",
                                   c, rf_we, forward_wb_wen, ws_allowin, e_rfwe, e_fwd, allow); end
            n_checks++; if (retired_cnt !== exp_ret) begin
                n_fail++; $display("FAIL rnd%0d_cnt: got %h want %h", c, retired_cnt, exp_ret); end
            if (m_valid) begin
                n_checks++; if (rf_wdata !== exp_w || forward_wb_wdata !== exp_w || rf_waddr !== m_dest || debug_wb_pc !== m_pc) begin
                    n_fail++; $display("FAIL rnd%0d_data: got wdata=%h fwd=%h waddr=%0d pc=%h want %h/%h/%0d/%h (op=%0d addr=%h)",
                                       c, rf_wdata, forward_wb_wdata, rf_waddr, debug_wb_pc, exp_w, exp_w, m_dest, m_pc, m_op, m_addr); end
            end
            if (commit) exp_ret++;
            if (ms_to_ws_valid && allow) begin
                m_valid = 1'b1; m_first = 1'b1;
                m_op = ms_ld_op; m_pc = ms_pc; m_addr = ms_alu_result;
                m_rt = ms_rt_value; m_dest = ms_dest; m_we = ms_rf_we;
            end else begin
                if (allow) m_valid = 1'b0;
                m_first = 1'b0;
            end
            tick();
        end
        idle_inputs();
        ws_flush = 1'b1;
        tick();
        ws_flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall;
        put(C_LW, 32'h600, 32'h0000_0800, 32'h0, 5'd6, 1'b1);
        tick();
        ms_to_ws_valid  = 1'b0;
        ws_stall        = 1'b1;
        data_sram_rdata = 32'hCAFE_F00D;
        settle();
        n_checks++; if (forward_wb_wen !== 1'b1 || forward_wb_wdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL rst_pre: got fwd=%b data=%h want 1/cafef00d", forward_wb_wen, forward_wb_wdata); end
        tick();
        #1;
        resetn = 1'b0;
        #1;
        exp_ret = 32'h0;
        n_checks++; if (rf_we !== 1'b0 || forward_wb_wen !== 1'b0 || ws_allowin !== 1'b1) begin
            n_fail++; $display("FAIL rst_async_ctrl: got we=%b fwd=%b allow=%b want 0/0/1", rf_we, forward_wb_wen, ws_allowin); end
        n_checks++; if (retired_cnt !== 32'h0 || debug_wb_pc !== C_PC_RST || rf_wdata !== 32'h0 || rf_waddr !== 5'd0) begin
            n_fail++; $display("FAIL rst_async_data: got cnt=%h pc=%h wdata=%h waddr=%0d want 0/%h/0/0",
                               retired_cnt, debug_wb_pc, rf_wdata, rf_waddr, C_PC_RST); end
        tick();
        resetn   = 1'b1;
        ws_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++; if (rf_we !== 1'b0 || retired_cnt !== 32'h0) begin
                n_fail++; $display("FAIL rst_after%0d: got we=%b cnt=%h want 0/0", i, rf_we, retired_cnt); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stall_hold();
        test_dest_zero();
        test_back_to_back();
        test_random();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
